xbee_uart_tx: RTL

XBEE_UART_TX -- requirements
Module: xbee_uart_tx

---
 rtl/xbee_uart_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/xbee_uart_tx.sv
// xbee_uart_tx: a send_data rising edge queues DataIn into a small FIFO; an
// 8N1 transmitter drains it LSB first with registered TxD/busy outputs.
module xbee_uart_tx #(
   parameter int BAUD       = 9600,
   parameter int DATA_WIDTH = 8,
   parameter int CLKFREQ    = 100_000_000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] DataIn,
   input  logic                  send_data,
   output logic                  TxD,
   output logic                  busy,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow
);
   localparam int DIV = CLKFREQ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int NW  = AW + 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
   localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         baud_q, baud_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;
   logic                  send_q;
   logic                  ovf_q;
   logic [AW-1:0]         wr_q, rd_q;
   logic [NW-1:0]         cnt_q;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  push_req, pop, push_ok, bit_end;

   assign full     = (cnt_q == CNT_FULL);
   assign empty    = (cnt_q == '0);
   assign push_req = send_data & ~send_q;
   assign pop      = (state_q == IDLE) & ~empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req & (~full | pop);
   assign bit_end  = (baud_q == BAUD_LAST);

   assign TxD      = txd_q;
   assign busy     = busy_q;
   assign overflow = ovf_q;

   always_ff @(posedge clk) begin
      if (!reset && push_ok) mem_q[wr_q] <= DataIn;
   end

   // Outputs are registered from the current state, so TxD trails state by one cycle.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      txd_d   = 1'b1;
      busy_d  = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d = mem_q[rd_q];
               baud_d  = '0;
               idx_d   = '0;
               state_d = START;
            end
         end
         START: begin
            txd_d = 1'b0;
            if (bit_end) begin
               baud_d  = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         DATA: begin
            txd_d = shift_q[idx_q];
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         send_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         send_q  <= send_data;
         if (push_req && !push_ok) ovf_q <= 1'b1;
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop) rd_q <= rd_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   cnt_q <= cnt_q + NW'(1);
            2'b01:   cnt_q <= cnt_q - NW'(1);
            default: ;
         endcase
      end
   end
endmodule
